// File: rtl/countdown_ctrl.sv
// countdown_ctrl
// Sequencing controller for the LED/seven-segment countdown timer.
// Debounces and one-pulses the start/pause and clear pushbuttons, divides
// the board clock into a count tick, and runs an IDLE/COUNT/PAUSE/DONE FSM
// that decrements a two-digit BCD seconds value.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pb_start  in   raw start/pause pushbutton, active high, asynchronous
//   pb_clr    in   raw clear pushbutton, active high, asynchronous
//   state     out  1 while counting (COUNT)
//   stop      out  1 while expired (DONE)
//   sec_tens  out  BCD tens digit of remaining seconds
//   sec_ones  out  BCD ones digit of remaining seconds
module countdown_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned DEB_DIV   = 250_000,
    parameter logic [3:0]  INIT_TENS = 4'd3,
    parameter logic [3:0]  INIT_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_start,
    input  logic       pb_clr,
    output logic       state,
    output logic       stop,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned DEB_W  = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_DIV - 1);
    localparam bit INIT_ZERO = (INIT_TENS == 4'd0) && (INIT_ONES == 4'd0);

    typedef enum logic [1:0] {IDLE, COUNT, PAUSE, DONE} fsm_t;

    fsm_t              fsm;
    logic [DEB_W-1:0]  deb_cnt;
    logic              sample_en;
    logic [1:0]        raw;
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0][3:0]   shreg;
    logic [1:0][3:0]   shift_next;
    logic [1:0]        level;
    logic [1:0]        level_d;
    logic [1:0]        pulse;
    logic              start_p;
    logic              clr_p;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              at_one;
    logic              at_zero;
    logic [3:0]        dec_tens;
    logic [3:0]        dec_ones;

    // Bit 0 carries the start/pause button, bit 1 the clear button.
    assign raw       = {pb_clr, pb_start};
    assign sample_en = (deb_cnt == DEB_LAST);

    // Shared debounce sample divider; both buttons are sampled on the same enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
        end else if (sample_en) begin
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign shift_next[0] = {shreg[0][2:0], sync2[0]};
    assign shift_next[1] = {shreg[1][2:0], sync2[1]};

    // Synchronize, debounce and one-pulse each button. The debounced level
    // is judged on the freshly shifted value so it moves on the same sample
    // that completes four agreeing samples; the pulse is a registered
    // rising-edge detect, so releasing or holding a button yields no extra pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            shreg   <= '0;
            level   <= '0;
            level_d <= '0;
            pulse   <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sample_en) begin
                shreg <= shift_next;
                for (int i = 0; i < 2; i++) begin
                    if (&shift_next[i]) begin
                        level[i] <= 1'b1;
                    end else if (~|shift_next[i]) begin
                        level[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign start_p = pulse[0];
    assign clr_p   = pulse[1];

    assign tick = (fsm == COUNT) && (tick_cnt == TICK_LAST);

    // Second counter: runs only while counting, holds the partial second
    // through PAUSE, and is parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            case (fsm)
                COUNT:   tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                PAUSE:   tick_cnt <= tick_cnt;
                default: tick_cnt <= '0;
            endcase
        end
    end

    assign at_one  = (sec_tens == 4'd0) && (sec_ones == 4'd1);
    assign at_zero = (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // BCD decrement with borrow from the tens digit.
    always_comb begin
        dec_ones = sec_ones - 4'd1;
        dec_tens = sec_tens;
        if (sec_ones == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = sec_tens - 4'd1;
        end
    end

    // Main FSM. Outputs are assigned alongside each transition so they
    // reflect the state being entered on the same edge. Clear overrides
    // everything; reaching 00 overrides a simultaneous pause request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            state    <= 1'b0;
            stop     <= 1'b0;
            sec_tens <= INIT_TENS;
            sec_ones <= INIT_ONES;
        end else if (clr_p) begin
            fsm      <= IDLE;
            state    <= 1'b0;
            stop     <= 1'b0;
            sec_tens <= INIT_TENS;
            sec_ones <= INIT_ONES;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start_p) begin
                        if (INIT_ZERO) begin
                            fsm  <= DONE;
                            stop <= 1'b1;
                        end else begin
                            fsm   <= COUNT;
                            state <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (tick && !at_zero) begin
                        sec_tens <= dec_tens;
                        sec_ones <= dec_ones;
                    end
                    if (tick && at_one) begin
                        fsm   <= DONE;
                        state <= 1'b0;
                        stop  <= 1'b1;
                    end else if (start_p) begin
                        fsm   <= PAUSE;
                        state <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_p) begin
                        fsm   <= COUNT;
                        state <= 1'b1;
                    end
                end
                DONE: begin
                    if (start_p) begin
                        fsm      <= IDLE;
                        stop     <= 1'b0;
                        sec_tens <= INIT_TENS;
                        sec_ones <= INIT_ONES;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    state <= 1'b0;
                    stop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
// Self-checking bench for countdown_ctrl. Three instances share a clock and
// reset: dut0 reloads 03, dut1 reloads 10 (borrow case), dut2 reloads 00.
// dut1 and dut2 share their button inputs.
module tb_countdown_ctrl;

    localparam int TICK = 10;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] SA   = 4'b1000;
    localparam logic [3:0] CA   = 4'b0100;
    localparam logic [3:0] SB   = 4'b0010;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic pb_start_a = 1'b0;
    logic pb_clr_a   = 1'b0;
    logic pb_start_b = 1'b0;
    logic pb_clr_b   = 1'b0;

    logic       st [3];
    logic       sp [3];
    logic [3:0] tn [3];
    logic [3:0] on [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_ctrl #(.TICK_DIV(TICK), .DEB_DIV(1), .INIT_TENS(4'd0), .INIT_ONES(4'd3)) dut0 (
        .clk(clk), .rst_n(rst_n), .pb_start(pb_start_a), .pb_clr(pb_clr_a),
        .state(st[0]), .stop(sp[0]), .sec_tens(tn[0]), .sec_ones(on[0]));

    countdown_ctrl #(.TICK_DIV(TICK), .DEB_DIV(1), .INIT_TENS(4'd1), .INIT_ONES(4'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .pb_start(pb_start_b), .pb_clr(pb_clr_b),
        .state(st[1]), .stop(sp[1]), .sec_tens(tn[1]), .sec_ones(on[1]));

    countdown_ctrl #(.TICK_DIV(TICK), .DEB_DIV(1), .INIT_TENS(4'd0), .INIT_ONES(4'd0)) dut2 (
        .clk(clk), .rst_n(rst_n), .pb_start(pb_start_b), .pb_clr(pb_clr_b),
        .state(st[2]), .stop(sp[2]), .sec_tens(tn[2]), .sec_ones(on[2]));

    // Behavioural model: remaining time is a plain integer of seconds and
    // elapsed cycles within the current second. Button pulses are derived
    // from a history of raw samples: the debounced level looks at the raw
    // values seen 2..5 edges ago, and a press acts two edges after the level rises.
    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_EXPIRED} mode_e;

    typedef struct {
        logic [7:0] hs;
        logic [7:0] hc;
        logic [2:0] ls;
        logic [2:0] lc;
        int         secs;
        int         elapsed;
        mode_e      mode;
    } mdl_t;

    mdl_t mdl [3];
    int   inits [3] = '{3, 10, 0};

    function automatic logic deb_level(input logic [7:0] h, input logic prev);
        if (h[5:2] == 4'hF) return 1'b1;
        if (h[5:2] == 4'h0) return 1'b0;
        return prev;
    endfunction

    function automatic mdl_t mdl_reset(input int init);
        mdl_t m;
        m.hs      = '0;
        m.hc      = '0;
        m.ls      = '0;
        m.lc      = '0;
        m.secs    = init;
        m.elapsed = 0;
        m.mode    = M_IDLE;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m_in, input logic s, input logic c, input int init);
        mdl_t m;
        logic start_pulse;
        logic clr_pulse;
        logic sec_end;
        m           = m_in;
        start_pulse = m.ls[1] & ~m.ls[2];
        clr_pulse   = m.lc[1] & ~m.lc[2];
        m.hs = {m.hs[6:0], s};
        m.hc = {m.hc[6:0], c};
        m.ls = {m.ls[1:0], deb_level(m.hs, m.ls[0])};
        m.lc = {m.lc[1:0], deb_level(m.hc, m.lc[0])};
        if (clr_pulse) begin
            m.mode    = M_IDLE;
            m.secs    = init;
            m.elapsed = 0;
        end else begin
            case (m.mode)
                M_IDLE: begin
                    m.elapsed = 0;
                    if (start_pulse) m.mode = (init == 0) ? M_EXPIRED : M_RUN;
                end
                M_RUN: begin
                    sec_end = (m.elapsed == TICK - 1);
                    if (sec_end) begin
                        m.elapsed = 0;
                        if (m.secs > 0) m.secs = m.secs - 1;
                    end else begin
                        m.elapsed = m.elapsed + 1;
                    end
                    if (sec_end && m.secs == 0) m.mode = M_EXPIRED;
                    else if (start_pulse)      m.mode = M_HOLD;
                end
                M_HOLD: begin
                    if (start_pulse) m.mode = M_RUN;
                end
                M_EXPIRED: begin
                    m.elapsed = 0;
                    if (start_pulse) begin
                        m.mode = M_IDLE;
                        m.secs = init;
                    end
                end
                default: m.mode = M_IDLE;
            endcase
        end
        return m;
    endfunction

    // Advance the model on every rising edge, or clear it as soon as reset asserts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mdl[i] = mdl_reset(inits[i]);
        end else begin
            mdl[0] = mdl_step(mdl[0], pb_start_a, pb_clr_a, inits[0]);
            mdl[1] = mdl_step(mdl[1], pb_start_b, pb_clr_b, inits[1]);
            mdl[2] = mdl_step(mdl[2], pb_start_b, pb_clr_b, inits[2]);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every falling edge, compare all outputs of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dut%0d.state", i), int'(st[i]), int'(mdl[i].mode == M_RUN));
            checkOutput($sformatf("dut%0d.stop", i), int'(sp[i]), int'(mdl[i].mode == M_EXPIRED));
            checkOutput($sformatf("dut%0d.sec_tens", i), int'(tn[i]), mdl[i].secs / 10);
            checkOutput($sformatf("dut%0d.sec_ones", i), int'(on[i]), mdl[i].secs % 10);
        end
    end

    // Drive {start_a, clr_a, start_b, clr_b} now and hold it for n rising edges.
    task automatic applyStimulus(input logic [3:0] v, input int n);
        {pb_start_a, pb_clr_a, pb_start_b, pb_clr_b} = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst.a.state", int'(st[0]), 0);
        checkOutput("rst.a.stop", int'(sp[0]), 0);
        checkOutput("rst.a.tens", int'(tn[0]), 0);
        checkOutput("rst.a.ones", int'(on[0]), 3);
        checkOutput("rst.b.tens", int'(tn[1]), 1);
        checkOutput("rst.b.ones", int'(on[1]), 0);
        rst_n = 1'b1;

        $display("[TB] basic run and pause/resume on dut0");
        applyStimulus(SA, 7);
        checkOutput("press.latency.state", int'(st[0]), 0);
        applyStimulus(SA, 1);
        checkOutput("press.state", int'(st[0]), 1);
        checkOutput("press.ones", int'(on[0]), 3);
        applyStimulus(NONE, 8);
        applyStimulus(SA, 1);
        checkOutput("rate.before.ones", int'(on[0]), 3);
        applyStimulus(SA, 1);
        checkOutput("rate.first.ones", int'(on[0]), 2);
        applyStimulus(SA, 5);
        checkOutput("prepause.state", int'(st[0]), 1);
        applyStimulus(SA, 1);
        checkOutput("pause.state", int'(st[0]), 0);
        checkOutput("pause.ones", int'(on[0]), 2);
        checkOutput("model.pause.elapsed", mdl[0].elapsed, 6);
        applyStimulus(NONE, 50);
        checkOutput("hold.state", int'(st[0]), 0);
        checkOutput("hold.ones", int'(on[0]), 2);
        applyStimulus(SA, 8);
        checkOutput("resume.state", int'(st[0]), 1);
        checkOutput("resume.ones", int'(on[0]), 2);
        applyStimulus(NONE, 3);
        checkOutput("resume3.ones", int'(on[0]), 2);
        applyStimulus(NONE, 1);
        checkOutput("resume4.ones", int'(on[0]), 1);
        applyStimulus(NONE, 9);
        checkOutput("preexpiry.stop", int'(sp[0]), 0);
        applyStimulus(NONE, 1);
        checkOutput("expiry.ones", int'(on[0]), 0);
        checkOutput("expiry.stop", int'(sp[0]), 1);
        checkOutput("expiry.state", int'(st[0]), 0);
        checkOutput("model.expiry.secs", mdl[0].secs, 0);

        $display("[TB] DONE exit");
        applyStimulus(SA, 8);
        checkOutput("doneexit.stop", int'(sp[0]), 0);
        checkOutput("doneexit.ones", int'(on[0]), 3);

        $display("[TB] bounce");
        applyStimulus(NONE, 10);
        for (int i = 0; i < 20; i++) applyStimulus((i % 2 == 0) ? SA : NONE, 1);
        applyStimulus(NONE, 10);
        checkOutput("bounce.state", int'(st[0]), 0);
        checkOutput("bounce.ones", int'(on[0]), 3);

        $display("[TB] long hold");
        applyStimulus(SA, 200);
        checkOutput("hold200.stop", int'(sp[0]), 1);
        checkOutput("hold200.ones", int'(on[0]), 0);
        applyStimulus(NONE, 10);
        applyStimulus(SA, 8);
        checkOutput("hold200.exit.ones", int'(on[0]), 3);
        applyStimulus(NONE, 6);

        $display("[TB] clear priority");
        applyStimulus(SA, 8);
        checkOutput("clr.run.state", int'(st[0]), 1);
        applyStimulus(NONE, 6);
        applyStimulus(SA | CA, 8);
        checkOutput("clr.state", int'(st[0]), 0);
        checkOutput("clr.stop", int'(sp[0]), 0);
        checkOutput("clr.ones", int'(on[0]), 3);
        applyStimulus(NONE, 6);

        $display("[TB] BCD borrow on dut1, zero reload on dut2");
        applyStimulus(SB, 8);
        checkOutput("b.start.state", int'(st[1]), 1);
        checkOutput("c.start.stop", int'(sp[2]), 1);
        checkOutput("c.start.state", int'(st[2]), 0);
        applyStimulus(NONE, 10);
        checkOutput("b.borrow.tens", int'(tn[1]), 0);
        checkOutput("b.borrow.ones", int'(on[1]), 9);
        applyStimulus(NONE, 80);
        checkOutput("b.late.ones", int'(on[1]), 1);
        applyStimulus(NONE, 10);
        checkOutput("b.end.ones", int'(on[1]), 0);
        checkOutput("b.end.stop", int'(sp[1]), 1);

        $display("[TB] async reset mid-count");
        applyStimulus(SA, 8);
        applyStimulus(NONE, 27);
        checkOutput("prereset.ones", int'(on[0]), 1);
        checkOutput("model.prereset.elapsed", mdl[0].elapsed, 7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst.state", int'(st[0]), 0);
        checkOutput("arst.stop", int'(sp[0]), 0);
        checkOutput("arst.ones", int'(on[0]), 3);
        checkOutput("arst.b.tens", int'(tn[1]), 1);
        checkOutput("arst.b.stop", int'(sp[1]), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(SA, 8);
        checkOutput("postrst.state", int'(st[0]), 1);
        applyStimulus(NONE, 9);
        checkOutput("postrst9.ones", int'(on[0]), 3);
        applyStimulus(NONE, 1);
        checkOutput("postrst10.ones", int'(on[0]), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the lab 5 LED/seven-segment countdown timer. It debounces and one-pulses the start/pause and clear pushbuttons and divides the board clock into a 1 s tick. A four-state FSM decrements a two-digit BCD seconds value and drives the `state` (counting) and `stop` (expired) controls of the LED display driver. The BCD digits feed the seven-segment scan block.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per count tick (1 s at 100 MHz); legal ≥ 2.
- `DEB_DIV`, 250_000: clk cycles between debounce samples; legal ≥ 1.
- `INIT_TENS`, 4'd3: reload value of tens digit (BCD, 0–9).
- `INIT_ONES`, 4'd0: reload value of ones digit (BCD, 0–9).
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `pb_start` in 1: raw start/pause pushbutton, active high, asynchronous to clk.
- `pb_clr` in 1: raw clear pushbutton, active high, asynchronous to clk.
- `state` out 1: 1 while in COUNT, to LED driver.
- `stop` out 1: 1 while in DONE, to LED driver.
- `sec_tens` out 4: BCD tens digit of remaining seconds.
- `sec_ones` out 4: BCD ones digit of remaining seconds.

## Operation
- **Input conditioning, per button.**
  - Two-flop synchronizer.
  - A shared sample-enable pulses once every `DEB_DIV` cycles.
  - On each sample-enable, shift the synchronized value into a 4-bit shift register.
  - Debounced level = 1 when all four bits are 1, 0 when all four are 0, otherwise hold.
  - One-pulse: a registered rising-edge detect on the debounced level gives a 1-cycle `start_p` / `clr_p`.
- **Tick generator.**
  - Counter runs 0..`TICK_DIV`-1 only in COUNT. `tick` is 1 for one cycle when counter = `TICK_DIV`-1, and the counter wraps to 0.
  - The counter holds its value in PAUSE, so the partial second is preserved.
  - The counter is forced to 0 in IDLE and DONE.
- **FSM states:** IDLE, COUNT, PAUSE, DONE. `clr_p` has priority over everything: from any state go to IDLE and reload digits from the INIT values.
  - IDLE: `start_p` → COUNT. If INIT is 00, `start_p` → DONE instead.
  - COUNT, on `tick`, BCD-decrement the digits:
    - If ones ≠ 0, ones−1.
    - Otherwise ones←9 and tens−1.
    - If the pre-decrement value is 01, the result is 00 and the FSM enters DONE on the same edge.
  - COUNT, on `start_p`: go to PAUSE.
  - COUNT, `tick` and `start_p` in the same cycle: apply the decrement, then go to PAUSE. If the decrement reaches 00, DONE wins over PAUSE.
  - PAUSE: `start_p` → COUNT. Digits are frozen.
  - DONE: digits hold 00. `start_p` → IDLE with digits reloaded from INIT.
- **Digit range:** digits never leave 0–9. No decrement occurs at 00.
- **Outputs:** all outputs are registered and decoded from the next state, so they change on the same edge as the state.

## Timing
- **Reset values** (`rst_n` low, immediate): FSM=IDLE, `state`=0, `stop`=0, `sec_tens`=`INIT_TENS`, `sec_ones`=`INIT_ONES`. Tick counter, divider, synchronizers, shift registers and edge registers all clear to 0.
- **Reset mid-count:** same values as above. The partial second is discarded.
- **Button latency:** a clean press stable from cycle 0 produces its pulse 2 sync cycles + 4 sample-enables + 1 edge-detect cycle later, at most 2+4·`DEB_DIV`+1 cycles. The state change happens on the next edge after the pulse.
- **Button release and bounce:**
  - Releasing a button produces no pulse.
  - Bounce shorter than 4 consecutive samples produces no pulse.
  - Holding a button produces exactly one pulse.
- **Count rate:** from COUNT entry out of IDLE, the first decrement occurs exactly `TICK_DIV` cycles later, then one decrement every `TICK_DIV` cycles.
- **Pause/resume:** after resume from PAUSE, the next decrement occurs after the remaining (`TICK_DIV` − held count) cycles.
- **Expiry:** `stop` rises on the same edge at which the digits become 00. `state` falls on that same edge.

## Test plan
- **Basic run:** `TICK_DIV`=10, `DEB_DIV`=1, INIT=03. Clean `pb_start` press → `state`=1. Digits go 03→02→01→00 at 10-cycle spacing. At the 00 edge, `stop`=1 and `state`=0.
- **Pause and resume:** pause at count value 6 while digits=02 → digits hold 02 for 50 cycles with `state`=0. Resume → digits become 01 exactly 4 cycles later.
- **BCD borrow:** INIT=10 → after one tick digits=09 (tens=0, ones=9). After 9 more ticks, 00 and DONE.
- **Clear priority and DONE exit:**
  - `pb_clr` and `pb_start` pulses in the same cycle during COUNT → IDLE, digits=INIT, `state`=`stop`=0.
  - In DONE, `pb_start` → IDLE, digits=INIT.
- **Debounce:** `pb_start` toggling every cycle for 20 cycles, then low → no state change. Press held 200 cycles → exactly one transition.
- **Async reset mid-count:** `rst_n` low at digits=01 with tick count 7 → outputs go to their reset values immediately. After release, a new start gives its first decrement after a full 10 cycles.
